// File: rtl/stream_mux_rr.sv
// ----------------------------------------------------------------------------
// stream_mux_rr : N-channel valid/ready stream mux, round-robin arbitration,
//                 registered output with per-word optional bitwise invert.
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stream_mux_rr #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   input  logic              invert,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   input  logic              out_ready
);

   localparam int PW = $clog2(N_CH);

   logic [PW-1:0] ptr;
   logic [PW-1:0] grant;
   logic [PW-1:0] ptr_next;
   logic [PW-1:0] cand;
   logic [PW:0]   sum;
   logic          any_valid;
   logic          load;
   logic          take;
   logic [W-1:0]  sel_data;

   // Scan ptr, ptr+1, ... modulo N_CH; the first valid channel wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < N_CH; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N_CH)) begin
            sum = sum - (PW+1)'(N_CH);
         end
         cand = sum[PW-1:0];
         if (!any_valid && in_valid[cand]) begin
            grant     = cand;
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant == PW'(i)) begin
            sel_data = in_data[i*W +: W];
         end
      end
   end

   assign ptr_next = (grant == PW'(N_CH-1)) ? '0 : grant + PW'(1);

   assign load = !rst && (!out_valid || out_ready);
   assign take = load && any_valid;

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_ready[i] = take && (grant == PW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         ptr       <= '0;
      end else if (load) begin
         out_valid <= any_valid;
         if (any_valid) begin
            out_data <= invert ? ~sel_data : sel_data;
            ptr      <= ptr_next;
         end
      end
   end

endmodule

`default_nettype wire
